// File: rtl/select_encode_seq.sv
// select_encode_seq: latches the IR, decodes Ra/Rb/Rc into a registered selection
// and drives one-hot register enables, sign-extended C and an operand-step FSM.
`default_nettype none

module select_encode_seq #(
   parameter int NREGS  = 16,
   parameter int RSEL_W = 4,
   parameter int IR_W   = 32,
   parameter int OPC_W  = 5,
   parameter int C_W    = 19,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [IR_W-1:0]   ir_in,
   input  logic              ir_load,
   input  logic              gra,
   input  logic              grb,
   input  logic              grc,
   input  logic              seq_start,
   input  logic              seq_step,
   input  logic              rin,
   input  logic              rout,
   input  logic              baout,
   output logic [NREGS-1:0]  r_in,
   output logic [NREGS-1:0]  r_out,
   output logic              ba_zero,
   output logic [OPC_W-1:0]  opcode,
   output logic [DATA_W-1:0] c_sign_e,
   output logic [RSEL_W-1:0] sel_idx,
   output logic              sel_valid,
   output logic              seq_busy,
   output logic              gr_conflict
);

   localparam int RA_MSB = IR_W - OPC_W - 1;

   typedef enum logic [1:0] {S_IDLE, S_OPA, S_OPB, S_OPC} state_t;

   state_t            state_q, state_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [RSEL_W-1:0] sel_idx_q, sel_idx_d;
   logic              sel_valid_q, sel_valid_d;
   logic              conflict_q, conflict_d;

   logic [RSEL_W-1:0] ra, rb, rc;
   logic              multi_gr;

   assign ra       = ir_q[RA_MSB -: RSEL_W];
   assign rb       = ir_q[RA_MSB - RSEL_W -: RSEL_W];
   assign rc       = ir_q[RA_MSB - 2*RSEL_W -: RSEL_W];
   assign multi_gr = (gra & grb) | (gra & grc) | (grb & grc);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= S_IDLE;
         ir_q        <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         sel_idx_q   <= sel_idx_d;
         sel_valid_q <= sel_valid_d;
         conflict_q  <= conflict_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      sel_idx_d   = sel_idx_q;
      sel_valid_d = sel_valid_q;
      conflict_d  = conflict_q;
      if (ir_load) begin
         ir_d        = ir_in;
         state_d     = S_IDLE;
         sel_valid_d = 1'b0;
         conflict_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Conflict is flagged even when seq_start takes the edge.
               if (multi_gr) conflict_d = 1'b1;
               if (seq_start) begin
                  state_d     = S_OPA;
                  sel_idx_d   = ra;
                  sel_valid_d = 1'b1;
               end else if (gra) begin
                  sel_idx_d   = ra;
                  sel_valid_d = 1'b1;
               end else if (grb) begin
                  sel_idx_d   = rb;
                  sel_valid_d = 1'b1;
               end else if (grc) begin
                  sel_idx_d   = rc;
                  sel_valid_d = 1'b1;
               end
            end
            S_OPA: if (seq_step) begin
               state_d   = S_OPB;
               sel_idx_d = rb;
            end
            S_OPB: if (seq_step) begin
               state_d   = S_OPC;
               sel_idx_d = rc;
            end
            default: if (seq_step) begin
               state_d     = S_IDLE;
               sel_valid_d = 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NREGS; k++) begin : g_onehot
      logic hit;
      assign hit      = sel_valid_q & (sel_idx_q == RSEL_W'(k));
      assign r_in[k]  = hit & rin;
      assign r_out[k] = hit & (rout | (baout & (k != 0)));
   end

   assign ba_zero     = sel_valid_q & baout & (sel_idx_q == '0);
   assign opcode      = ir_q[IR_W-1 -: OPC_W];
   assign c_sign_e    = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
   assign sel_idx     = sel_idx_q;
   assign sel_valid   = sel_valid_q;
   assign seq_busy    = (state_q != S_IDLE);
   assign gr_conflict = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_select_encode_seq.sv
// tb_select_encode_seq: directed self-checking bench for select_encode_seq.
`default_nettype none

module tb_select_encode_seq;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] ir_in = '0;
   logic        ir_load = 0, gra = 0, grb = 0, grc = 0;
   logic        seq_start = 0, seq_step = 0, rin = 0, rout = 0, baout = 0;
   logic [15:0] r_in, r_out;
   logic        ba_zero;
   logic [4:0]  opcode;
   logic [31:0] c_sign_e;
   logic [3:0]  sel_idx;
   logic        sel_valid, seq_busy, gr_conflict;

   int checks = 0;
   int errors = 0;

   select_encode_seq dut (
      .clock(clock), .clear(clear), .ir_in(ir_in), .ir_load(ir_load),
      .gra(gra), .grb(grb), .grc(grc), .seq_start(seq_start), .seq_step(seq_step),
      .rin(rin), .rout(rout), .baout(baout),
      .r_in(r_in), .r_out(r_out), .ba_zero(ba_zero), .opcode(opcode),
      .c_sign_e(c_sign_e), .sel_idx(sel_idx), .sel_valid(sel_valid),
      .seq_busy(seq_busy), .gr_conflict(gr_conflict)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_ir(input logic [31:0] v);
      ir_in = v; ir_load = 1'b1;
      tick();
      ir_load = 1'b0; ir_in = '0;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({r_in, r_out, ba_zero, opcode, c_sign_e, sel_idx, sel_valid, seq_busy, gr_conflict} !== '0) begin
         errors++;
         $display("FAIL %s: r_in=%h r_out=%h ba_zero=%b opcode=%h c=%h sel=%h valid=%b busy=%b conf=%b, all required 0",
                  name, r_in, r_out, ba_zero, opcode, c_sign_e, sel_idx, sel_valid, seq_busy, gr_conflict);
      end
   endtask

   task automatic test_reset();
      #2 clear = 1'b0;
      ir_in = '1; {ir_load, gra, grb, grc, seq_start, seq_step, rin, rout, baout} = '1;
      tick(); tick();
      check_all_zero("reset_inputs_high");
      {ir_load, gra, grb, grc, seq_start, seq_step, rin, rout, baout} = '0;
      ir_in = '0;
      clear = 1'b1;
      tick(); tick();
      check_all_zero("after_release");
   endtask

   task automatic test_manual();
      load_ir(32'h0A9A_0000);
      checks++;
      if (opcode !== 5'h01 || c_sign_e !== 32'h0002_0000 || sel_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_fields: opcode=%h c=%h valid=%b, required 01 00020000 0", opcode, c_sign_e, sel_valid);
      end
      gra = 1'b1; tick(); gra = 1'b0;
      rout = 1'b1; #1;
      checks++;
      if (r_out !== 16'h0020 || sel_idx !== 4'd5 || sel_valid !== 1'b1) begin
         errors++;
         $display("FAIL gra_rout: r_out=%h sel=%h valid=%b, required 0020 5 1", r_out, sel_idx, sel_valid);
      end
      rout = 1'b0;
      grc = 1'b1; rin = 1'b1; tick(); grc = 1'b0;
      checks++;
      if (r_in !== 16'h0010 || r_out !== 16'h0000 || gr_conflict !== 1'b0) begin
         errors++;
         $display("FAIL grc_rin: r_in=%h r_out=%h conf=%b, required 0010 0000 0", r_in, r_out, gr_conflict);
      end
      rin = 1'b0; tick();
      checks++;
      if (sel_idx !== 4'd4 || sel_valid !== 1'b1 || r_in !== 16'h0000) begin
         errors++;
         $display("FAIL hold_sel: sel=%h valid=%b r_in=%h, required 4 1 0000", sel_idx, sel_valid, r_in);
      end
   endtask

   task automatic test_sequence();
      logic [15:0] exp_out [4];
      int busy_cycles;
      exp_out[0] = 16'h0020; exp_out[1] = 16'h0008; exp_out[2] = 16'h0010; exp_out[3] = 16'h0000;
      busy_cycles = 0;
      rout = 1'b1; seq_start = 1'b1;
      tick();
      seq_start = 1'b0; seq_step = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (seq_busy === 1'b1) busy_cycles++;
         checks++;
         if (r_out !== exp_out[i]) begin
            errors++;
            $display("FAIL seq_step%0d: r_out=%h, required %h", i, r_out, exp_out[i]);
         end
         if (i < 3) tick();
      end
      seq_step = 1'b0; rout = 1'b0;
      checks++;
      if (busy_cycles != 3 || sel_valid !== 1'b0) begin
         errors++;
         $display("FAIL seq_busy_len: busy=%0d valid=%b, required 3 0", busy_cycles, sel_valid);
      end
   endtask

   task automatic test_baout();
      load_ir(32'h0282_0000);
      grb = 1'b1; tick(); grb = 1'b0;
      baout = 1'b1; #1;
      checks++;
      if (ba_zero !== 1'b1 || r_out !== 16'h0000 || sel_idx !== 4'd0) begin
         errors++;
         $display("FAIL baout_r0: ba_zero=%b r_out=%h sel=%h, required 1 0000 0", ba_zero, r_out, sel_idx);
      end
      baout = 1'b0; rout = 1'b1; #1;
      checks++;
      if (ba_zero !== 1'b0 || r_out !== 16'h0001) begin
         errors++;
         $display("FAIL rout_r0: ba_zero=%b r_out=%h, required 0 0001", ba_zero, r_out);
      end
      rout = 1'b0;
   endtask

   task automatic test_constants();
      load_ir(32'h0004_0001);
      checks++;
      if (c_sign_e !== 32'hFFFC_0001 || sel_valid !== 1'b0 || opcode !== 5'h00) begin
         errors++;
         $display("FAIL const_neg: c=%h valid=%b opcode=%h, required FFFC0001 0 00", c_sign_e, sel_valid, opcode);
      end
      load_ir(32'hF803_FFFF);
      checks++;
      if (c_sign_e !== 32'h0003_FFFF || opcode !== 5'h1F) begin
         errors++;
         $display("FAIL const_pos: c=%h opcode=%h, required 0003FFFF 1F", c_sign_e, opcode);
      end
   endtask

   task automatic test_conflict_abort();
      load_ir(32'h0A9A_0000);
      gra = 1'b1; grb = 1'b1; tick(); gra = 1'b0; grb = 1'b0;
      baout = 1'b1; #1;
      checks++;
      if (gr_conflict !== 1'b1 || sel_idx !== 4'd5 || r_out !== 16'h0020 || ba_zero !== 1'b0) begin
         errors++;
         $display("FAIL conflict: conf=%b sel=%h r_out=%h ba_zero=%b, required 1 5 0020 0",
                  gr_conflict, sel_idx, r_out, ba_zero);
      end
      baout = 1'b0;
      seq_start = 1'b1; tick(); seq_start = 1'b0;
      seq_step = 1'b1; tick(); seq_step = 1'b0;
      grc = 1'b1; tick(); grc = 1'b0;
      checks++;
      if (seq_busy !== 1'b1 || sel_idx !== 4'd3 || gr_conflict !== 1'b1) begin
         errors++;
         $display("FAIL opb_sticky: busy=%b sel=%h conf=%b, required 1 3 1", seq_busy, sel_idx, gr_conflict);
      end
      load_ir(32'h0A9A_0000);
      checks++;
      if (seq_busy !== 1'b0 || sel_valid !== 1'b0 || gr_conflict !== 1'b0) begin
         errors++;
         $display("FAIL abort_load: busy=%b valid=%b conf=%b, required 0 0 0", seq_busy, sel_valid, gr_conflict);
      end
      seq_start = 1'b1; tick(); seq_start = 1'b0;
      grb = 1'b1; grc = 1'b1; tick(); grb = 1'b0; grc = 1'b0;
      checks++;
      if (gr_conflict !== 1'b0 || sel_idx !== 4'd5 || seq_busy !== 1'b1) begin
         errors++;
         $display("FAIL gr_busy_ignored: conf=%b sel=%h busy=%b, required 0 5 1", gr_conflict, sel_idx, seq_busy);
      end
      rout = 1'b1; rin = 1'b1; #2;
      clear = 1'b0; #1;
      check_all_zero("async_clear_opa");
      rout = 1'b0; rin = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      check_all_zero("after_clear_release");
   endtask

   initial begin
      test_reset();
      test_manual();
      test_sequence();
      test_baout();
      test_constants();
      test_conflict_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
